w_expand: RTL and testbench
===========================

Name: w_expand

Overview:
- Downstream neighbour of the W-array delay/alignment stage in the SHA-256 miner pipeline.
- Accepts one 16-word message block (`WARR_S bits) on a single-cycle enable pulse.
- Streams the 64-entry SHA-256 message schedule W_0..W_63, one 32-bit word per cycle, to the compression-round datapath.
- Keeps a sliding 16-word window internally, so the full 64-word array is never stored.

Parameters:
- ROUNDS, 64, number of schedule words emitted per block; must be between 16 and 64.
- WORD_W, 32, word width; fixed at 32 for SHA-256.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  single-cycle start pulse; W_in is valid in the same cycle.
- W_in  in  `WARR_S  message block; W_in[511:480] = W_0 … W_in[31:0] = W_15.
- hold  in  1  stall from downstream; freezes the stream while high.
- ready  out  1  high when idle; en is honoured only when ready is high.
- w_valid  out  1  high while w_out carries a schedule word.
- w_out  out  WORD_W  current schedule word W_t.
- t_idx  out  6  index t of w_out.
- w_last  out  1  high together with w_valid when t_idx == ROUNDS-1.

Behaviour:
- Reset (synchronous, wins over every other input):
  - state=IDLE, ready=1, w_valid=0, w_last=0, w_out=0, t_idx=0.
  - Window registers cleared to 0.
  - Reset mid-stream aborts the block; no further words are emitted.
- States: IDLE, RUN.
- IDLE:
  - ready=1, w_valid=0.
  - On an edge with en=1 (hold ignored), load window win[0..15] from W_in and go to RUN.
  - After that edge: w_valid=1, w_out=W_0, t_idx=0.
  - Latency: 1 edge from en to first valid word.
- RUN:
  - ready=0; en is ignored (no queuing, no error flag).
  - Edge with hold=1: all state and outputs unchanged.
  - Edge with hold=0 and t_idx<ROUNDS-1: t_idx increments, and w_out becomes the next word:
    - t+1 ≤ 15: w_out = W_in word t+1, taken from the window.
    - t+1 ≥ 16: w_out = computed word, shifted into the window (the oldest word drops out).
  - Edge with hold=0 and t_idx==ROUNDS-1: go to IDLE; w_valid=0, w_last=0, ready=1.
  - w_out and t_idx hold their last values in IDLE; only w_valid qualifies them.
- Recurrence, all additions mod 2^32 with carries discarded:
  - W_t = σ1(W_{t-2}) + W_{t-7} + σ0(W_{t-15}) + W_{t-16}
  - σ0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x)
  - σ1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x)
- Timing: the next word is computed combinationally from window registers and registered into w_out. Maximum one 4-input 32-bit add per cycle; pipelining this add must not change the cycle behaviour above.
- Back-to-back blocks: earliest accepted en is the edge after the one that returns the block to IDLE. Minimum gap is 1 cycle with w_valid=0.
- en and reset on the same edge: reset wins, the block is not loaded.
- hold during IDLE has no effect.
- Throughput with hold=0: ROUNDS valid cycles plus 1 idle cycle per block.

Test Plan:
- "abc" block:
  - Stimulus: W_in = 0x61626380, fourteen zero words, then 0x00000018; pulse en with hold=0.
  - Required: exactly 64 consecutive w_valid cycles, t_idx 0..63.
  - Spot values: W_0=0x61626380, W_15=0x00000018, W_16=0x61626380, W_17=0x000F0000.
  - All 64 words match the golden SHA-256 model; w_last only at t_idx=63; ready=1 on the following cycle.
- All-zero block -> w_out=0 for all 64 words; w_valid high for 64 cycles, then low.
- Stall:
  - Stimulus: "abc" block, hold=1 for 3 cycles while t_idx=20, and for 1 cycle at t_idx=63.
  - Required: w_out and t_idx frozen during hold; word sequence identical to the no-stall run; total valid cycles = 68.
- en while busy:
  - Stimulus: second en with a different W_in at t_idx=10 and again at t_idx=63.
  - Required: both ignored; the stream completes with the first block; ready stays 0 until after W_63.
- Reset mid-run:
  - Stimulus: assert reset at t_idx=30 for 1 cycle.
  - Required: next cycle w_valid=0, ready=1, w_out=0, t_idx=0.
  - A new en then produces a correct full stream.
- Reset+en same edge -> block not loaded, w_valid stays 0. Back-to-back blocks A, B with minimum gap -> exactly one idle cycle between w_last of A and W_0 of B.

Source files
------------

// File: rtl/w_expand.sv
// SHA-256 message schedule expander: loads one 16-word block and streams
// W_0..W_{ROUNDS-1}, one word per cycle, from a sliding 16-word window.
module w_expand #(
    parameter int unsigned ROUNDS = 64,
    parameter int unsigned WORD_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [16*WORD_W-1:0]  W_in,
    input  logic                  hold,
    output logic                  ready,
    output logic                  w_valid,
    output logic [WORD_W-1:0]     w_out,
    output logic [5:0]            t_idx,
    output logic                  w_last
);

    localparam int unsigned WIN_N  = 16;
    localparam logic [5:0]  T_LAST = 6'(ROUNDS - 1);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t              r_state;
    logic                r_ready;
    logic                r_valid;
    logic                r_last;
    logic [WORD_W-1:0]   r_wout;
    logic [5:0]          r_t;
    logic [WORD_W-1:0]   r_win [WIN_N];

    logic [WORD_W-1:0]   w_s0;
    logic [WORD_W-1:0]   w_s1;
    logic [WORD_W-1:0]   w_calc;
    logic [WORD_W-1:0]   w_next;

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x,
                                               input int unsigned n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    // Window holds W_{t-15}..W_t once t >= 15; before that it is the raw block.
    always_comb begin
        w_s0   = rotr(r_win[1], 7) ^ rotr(r_win[1], 18) ^ (r_win[1] >> 3);
        w_s1   = rotr(r_win[14], 17) ^ rotr(r_win[14], 19) ^ (r_win[14] >> 10);
        w_calc = w_s1 + r_win[9] + w_s0 + r_win[0];
        w_next = (r_t < 6'd15) ? r_win[4'(r_t + 6'd1)] : w_calc;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_wout  <= '0;
            r_t     <= '0;
            for (int k = 0; k < WIN_N; k++) begin
                r_win[k] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (en) begin
                        for (int k = 0; k < WIN_N; k++) begin
                            r_win[k] <= W_in[(WIN_N - 1 - k) * WORD_W +: WORD_W];
                        end
                        r_wout  <= W_in[16*WORD_W-1 -: WORD_W];
                        r_t     <= '0;
                        r_valid <= 1'b1;
                        r_last  <= 1'b0;
                        r_ready <= 1'b0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (!hold) begin
                        if (r_t == T_LAST) begin
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            r_ready <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_t    <= r_t + 6'd1;
                            r_wout <= w_next;
                            r_last <= ((r_t + 6'd1) == T_LAST);
                            if (r_t >= 6'd15) begin
                                for (int k = 0; k < WIN_N - 1; k++) begin
                                    r_win[k] <= r_win[k + 1];
                                end
                                r_win[WIN_N - 1] <= w_calc;
                            end
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ready   = r_ready;
    assign w_valid = r_valid;
    assign w_out   = r_wout;
    assign t_idx   = r_t;
    assign w_last  = r_last;

endmodule

// File: tb/tb_w_expand.sv
// Self-checking bench for w_expand: spot-value table, reference schedule model,
// stall / busy-en / reset / back-to-back sequences and random blocks.
module tb_w_expand;

    localparam int ROUNDS = 64;

    logic         clk = 1'b0;
    logic         reset;
    logic         en;
    logic [511:0] W_in;
    logic         hold;
    logic         ready;
    logic         w_valid;
    logic [31:0]  w_out;
    logic [5:0]   t_idx;
    logic         w_last;

    int nchecks = 0;
    int nerr    = 0;

    logic [31:0] cap [64];

    w_expand dut (
        .clk(clk), .reset(reset), .en(en), .W_in(W_in), .hold(hold),
        .ready(ready), .w_valid(w_valid), .w_out(w_out), .t_idx(t_idx),
        .w_last(w_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x} >> n;
        return d[31:0];
    endfunction

    // Straight textbook schedule: full 64-entry array from the block.
    function automatic void model(input logic [511:0] blk, output logic [31:0] w [64]);
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            w[i] = (rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10))
                 + w[i-7]
                 + (rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3))
                 + w[i-16];
        end
    endfunction

    function automatic logic [511:0] rand_block();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
        return b;
    endfunction

    // Pulse en, then follow the stream to its end, checking every sample.
    task automatic run_stream(input logic [511:0] blk, input int stall20, input bit stall63,
                              input bit busy_en, input bit en_hold, input logic [511:0] alt,
                              output int nvalid);
        logic [31:0] exp [64];
        int          nwords;
        int          stall_left;
        bit          did20, did63, prev_hold, done;
        logic [31:0] pw;
        logic [5:0]  pt;
        int          cyc;
        model(blk, exp);
        nwords = 0; stall_left = 0; did20 = 0; did63 = 0; prev_hold = 0; done = 0;
        cyc = 0; nvalid = 0; pw = '0; pt = '0;
        en = 1'b1; W_in = blk; hold = en_hold;
        @(negedge clk);
        en = 1'b0; W_in = alt; hold = 1'b0;
        while (!done && cyc < 300) begin
            cyc++;
            if (w_valid) begin
                nvalid++;
                if (prev_hold) begin
                    chk("hold_w_out", w_out, pw);
                    chk("hold_t_idx", 32'(t_idx), 32'(pt));
                end else begin
                    if (t_idx !== 6'(nwords) || w_out !== exp[nwords % 64]) begin
                        chk("stream_t_idx", 32'(t_idx), 32'(nwords));
                        chk("stream_w_out", w_out, exp[nwords % 64]);
                    end else begin
                        nchecks++;
                    end
                    if (nwords < 64) cap[nwords] = w_out;
                    nwords++;
                end
                if (w_last !== (t_idx == 6'(ROUNDS - 1)) || ready !== 1'b0) begin
                    chk("w_last_run", 32'(w_last), 32'(t_idx == 6'(ROUNDS - 1)));
                    chk("ready_run", 32'(ready), 32'd0);
                end
                pw = w_out; pt = t_idx;
                hold = 1'b0;
                if (stall_left > 0) begin
                    hold = 1'b1; stall_left--;
                end else if (t_idx == 6'd20 && stall20 > 0 && !did20) begin
                    did20 = 1; stall_left = stall20 - 1; hold = 1'b1;
                end else if (t_idx == 6'd63 && stall63 && !did63) begin
                    did63 = 1; hold = 1'b1;
                end
                en = busy_en && (t_idx == 6'd10 || t_idx == 6'd63);
                prev_hold = hold;
            end else begin
                done = 1;
                if (nwords == 0) chk("first_word_latency", 32'(w_valid), 32'd1);
                else begin
                    chk("words_per_block", 32'(nwords), 32'(ROUNDS));
                    chk("ready_after_last", 32'(ready), 32'd1);
                    chk("w_last_idle", 32'(w_last), 32'd0);
                end
            end
            if (!done) @(negedge clk);
        end
        if (!done) chk("stream_timeout", 32'(cyc), 32'd0);
        en = 1'b0; hold = 1'b0;
    endtask

    typedef struct {
        string       name;
        int          blk_sel;
        int          t;
        logic [31:0] exp;
    } spot_t;

    spot_t        spots [7];
    logic [31:0]  cap_abc  [64];
    logic [31:0]  cap_zero [64];
    logic [511:0] abc_blk;
    int           nv;
    int           cyc;

    initial begin
        spots[0] = '{"abc_W0",   0, 0,  32'h61626380};
        spots[1] = '{"abc_W15",  0, 15, 32'h00000018};
        spots[2] = '{"abc_W16",  0, 16, 32'h61626380};
        spots[3] = '{"abc_W17",  0, 17, 32'h000F0000};
        spots[4] = '{"zero_W0",  1, 0,  32'h0};
        spots[5] = '{"zero_W31", 1, 31, 32'h0};
        spots[6] = '{"zero_W63", 1, 63, 32'h0};

        abc_blk = '0;
        abc_blk[511:480] = 32'h61626380;
        abc_blk[31:0]    = 32'h00000018;

        reset = 1'b1; en = 1'b0; hold = 1'b0; W_in = '0;
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        chk("rst_ready",   32'(ready),   32'd1);
        chk("rst_w_valid", 32'(w_valid), 32'd0);
        chk("rst_w_out",   w_out,        32'd0);
        chk("rst_t_idx",   32'(t_idx),   32'd0);
        chk("rst_w_last",  32'(w_last),  32'd0);

        // hold in IDLE does nothing
        hold = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_hold_valid", 32'(w_valid), 32'd0);
        chk("idle_hold_ready", 32'(ready),   32'd1);
        hold = 1'b0;

        run_stream(abc_blk, 0, 0, 0, 0, '0, nv);
        chk("abc_valid_cycles", 32'(nv), 32'd64);
        for (int i = 0; i < 64; i++) cap_abc[i] = cap[i];
        run_stream('0, 0, 0, 0, 1, '0, nv);
        chk("zero_valid_cycles", 32'(nv), 32'd64);
        for (int i = 0; i < 64; i++) cap_zero[i] = cap[i];

        for (int i = 0; i < 7; i++) begin
            chk(spots[i].name,
                (spots[i].blk_sel == 0) ? cap_abc[spots[i].t] : cap_zero[spots[i].t],
                spots[i].exp);
        end

        // stall at t=20 for 3 edges and at t=63 for 1 edge, with busy en pulses
        run_stream(abc_blk, 3, 1, 1, 0, rand_block(), nv);
        chk("stall_valid_cycles", 32'(nv), 32'd68);
        for (int i = 0; i < 64; i++) begin
            if (cap[i] !== cap_abc[i]) chk("stall_seq_match", cap[i], cap_abc[i]);
        end

        // reset mid-run at t=30
        en = 1'b1; W_in = rand_block();
        @(negedge clk);
        en = 1'b0;
        cyc = 0;
        while (!(w_valid && t_idx == 6'd30) && cyc < 100) begin
            @(negedge clk); cyc++;
        end
        chk("reach_t30", 32'(t_idx), 32'd30);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_w_valid", 32'(w_valid), 32'd0);
        chk("midrst_ready",   32'(ready),   32'd1);
        chk("midrst_w_out",   w_out,        32'd0);
        chk("midrst_t_idx",   32'(t_idx),   32'd0);
        @(negedge clk);
        chk("midrst_stays_idle", 32'(w_valid), 32'd0);
        run_stream(rand_block(), 0, 0, 0, 0, '0, nv);

        // reset and en on the same edge
        reset = 1'b1; en = 1'b1; W_in = abc_blk;
        @(negedge clk);
        reset = 1'b0; en = 1'b0;
        chk("rst_en_valid", 32'(w_valid), 32'd0);
        @(negedge clk);
        chk("rst_en_valid_later", 32'(w_valid), 32'd0);
        chk("rst_en_ready", 32'(ready), 32'd1);

        // back-to-back random blocks at minimum gap
        for (int b = 0; b < 4; b++) begin
            run_stream(rand_block(), (b == 1) ? 2 : 0, 0, (b == 2), 0, rand_block(), nv);
        end

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=timeout required=finish");
        $fatal(1);
    end

endmodule
